// File: rtl/bp_nonsynth_io_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// bp_nonsynth_io_cmd_arbiter
//
// Shares one io_cmd/io_resp channel pair among num_req_p simulation-only
// requesters (NBF loader, host/debug shim, freeze/reset sequencer) that sit
// in front of the IO network.
//   - Round-robin arbitration. Once a requester is offered on io_cmd_o, the
//     grant is locked to it until the network takes the command.
//   - The number of commands in flight is capped at max_credits_p.
//   - Every accepted command pushes its requester id into a tag FIFO. Each
//     io_resp is steered to the requester at the FIFO head, so responses
//     return in issue order.
//
// Parameters
//   num_req_p      number of requesters (>= 1); requester 0 is the NBF loader
//   max_credits_p  max commands in flight (>= 1); also the tag FIFO depth
//   msg_width_p    width of one cce_mem_msg
//
// Ports
//   clk_i             clock
//   reset_i           synchronous reset, active-high
//   req_cmd_i         per-requester command; slot i at [i*msg_width_p +: msg_width_p]
//   req_cmd_v_i       per-requester command valid
//   req_cmd_yumi_o    one-hot; the command of requester i is taken this cycle
//   req_resp_o        io_resp_i, broadcast to all requesters
//   req_resp_v_o      one-hot; the response belongs to requester i
//   req_resp_ready_i  per-requester response ready
//   io_cmd_o          granted command
//   io_cmd_v_o        command valid (valid->yumi handshake)
//   io_cmd_yumi_i     network takes io_cmd_o
//   io_resp_i         response from the network
//   io_resp_v_i       response valid
//   io_resp_ready_o   response consumed when io_resp_v_i & io_resp_ready_o
//   idle_o            no grant locked and no commands in flight
// ---------------------------------------------------------------------------
module bp_nonsynth_io_cmd_arbiter #(
   parameter int num_req_p     = 2,
   parameter int max_credits_p = 2,
   parameter int msg_width_p   = 64
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
   input  logic [num_req_p-1:0]             req_cmd_v_i,
   output logic [num_req_p-1:0]             req_cmd_yumi_o,
   output logic [msg_width_p-1:0]           req_resp_o,
   output logic [num_req_p-1:0]             req_resp_v_o,
   input  logic [num_req_p-1:0]             req_resp_ready_i,
   output logic [msg_width_p-1:0]           io_cmd_o,
   output logic                             io_cmd_v_o,
   input  logic                             io_cmd_yumi_i,
   input  logic [msg_width_p-1:0]           io_resp_i,
   input  logic                             io_resp_v_i,
   output logic                             io_resp_ready_o,
   output logic                             idle_o
);

   localparam int req_id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int credit_width_lp  = $clog2(max_credits_p + 1);
   localparam int tag_ptr_width_lp = (max_credits_p > 1) ? $clog2(max_credits_p) : 1;

   typedef logic [req_id_width_lp-1:0]  req_id_t;
   typedef logic [credit_width_lp-1:0]  credit_t;
   typedef logic [tag_ptr_width_lp-1:0] tag_ptr_t;
   typedef logic [req_id_width_lp:0]    req_sum_t;

   localparam credit_t  max_credits_lp = credit_t'(max_credits_p);
   localparam tag_ptr_t last_slot_lp   = tag_ptr_t'(max_credits_p - 1);
   localparam req_id_t  last_req_lp    = req_id_t'(num_req_p - 1);
   localparam req_sum_t num_req_lp     = req_sum_t'(num_req_p);

   typedef enum logic {
      e_arb,      // free: pick a requester round-robin each cycle
      e_locked    // command offered but not yet taken; hold lock_id_r
   } lock_state_e;

   lock_state_e state_r, state_n;
   req_id_t     lock_id_r, lock_id_n;
   req_id_t     rr_ptr_r, rr_ptr_n;
   credit_t     credit_cnt_r, credit_cnt_n;
   tag_ptr_t    rd_ptr_r, wr_ptr_r;
   req_id_t     tag_mem [max_credits_p];

   logic [2*num_req_p-1:0]   v_rot;
   logic [msg_width_p-1:0]   req_cmd_arr [num_req_p];
   req_sum_t                 pick_sum;
   req_id_t                  pick_id;
   req_id_t                  grant_id;
   req_id_t                  head_id;
   logic                     fifo_empty;
   logic                     accept;
   logic                     resp_deq;

   // Rotate the valids so that bit 0 is the requester at rr_ptr_r; the
   // lowest set bit of the rotated vector is then the round-robin winner.
   // NOTE: every signal driven from always_comb gets a default value first,
   // so no path through the block can leave it unassigned and infer a latch.
   always_comb begin
      v_rot    = {req_cmd_v_i, req_cmd_v_i} >> rr_ptr_r;
      pick_sum = {1'b0, rr_ptr_r};
      for (int k = num_req_p - 1; k >= 0; k--) begin
         if (v_rot[k]) begin
            pick_sum = {1'b0, rr_ptr_r} + req_sum_t'(k);
         end
      end
      if (pick_sum >= num_req_lp) begin
         pick_sum = pick_sum - num_req_lp;
      end
      pick_id = pick_sum[req_id_width_lp-1:0];
   end

   always_comb begin
      for (int i = 0; i < num_req_p; i++) begin
         req_cmd_arr[i] = req_cmd_i[i*msg_width_p +: msg_width_p];
      end
   end

   // The tag FIFO holds exactly one entry per outstanding command, so its
   // occupancy is credit_cnt_r and no separate count is needed.
   assign fifo_empty = (credit_cnt_r == '0);
   assign head_id    = tag_mem[rd_ptr_r];

   assign grant_id   = (state_r == e_locked) ? lock_id_r : pick_id;
   assign io_cmd_o   = req_cmd_arr[grant_id];
   assign io_cmd_v_o = ((state_r == e_locked) | (|req_cmd_v_i))
                       & (credit_cnt_r < max_credits_lp);
   assign accept     = io_cmd_v_o & io_cmd_yumi_i;

   assign req_resp_o      = io_resp_i;
   assign io_resp_ready_o = ~fifo_empty & req_resp_ready_i[head_id];
   assign resp_deq        = io_resp_v_i & io_resp_ready_o;

   assign idle_o = (state_r == e_arb) & fifo_empty;

   always_comb begin
      for (int i = 0; i < num_req_p; i++) begin
         req_cmd_yumi_o[i] = accept & (grant_id == req_id_t'(i));
         req_resp_v_o[i]   = io_resp_v_i & ~fifo_empty & (head_id == req_id_t'(i));
      end
   end

   // Lock / round-robin / credit next-state logic.
   always_comb begin
      state_n      = state_r;
      lock_id_n    = lock_id_r;
      rr_ptr_n     = rr_ptr_r;
      credit_cnt_n = credit_cnt_r;

      case (state_r)
         e_arb: begin
            // With credits exhausted io_cmd_v_o is low, so no lock is taken.
            if (io_cmd_v_o && !io_cmd_yumi_i) begin
               state_n   = e_locked;
               lock_id_n = pick_id;
            end
         end
         e_locked: begin
            if (accept) begin
               state_n = e_arb;
            end
         end
         default: state_n = e_arb;
      endcase

      if (accept) begin
         rr_ptr_n = (grant_id == last_req_lp) ? '0 : grant_id + 1'b1;
      end

      case ({accept, resp_deq})
         2'b10:   credit_cnt_n = credit_cnt_r + 1'b1;
         2'b01:   credit_cnt_n = credit_cnt_r - 1'b1;
         default: credit_cnt_n = credit_cnt_r;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r      <= e_arb;
         lock_id_r    <= '0;
         rr_ptr_r     <= '0;
         credit_cnt_r <= '0;
         rd_ptr_r     <= '0;
         wr_ptr_r     <= '0;
      end else begin
         state_r      <= state_n;
         lock_id_r    <= lock_id_n;
         rr_ptr_r     <= rr_ptr_n;
         credit_cnt_r <= credit_cnt_n;
         if (accept) begin
            wr_ptr_r <= (wr_ptr_r == last_slot_lp) ? '0 : wr_ptr_r + 1'b1;
         end
         if (resp_deq) begin
            rd_ptr_r <= (rd_ptr_r == last_slot_lp) ? '0 : rd_ptr_r + 1'b1;
         end
      end
   end

   // NOTE: the tag storage is not reset; an entry is only read after it has
   // been written, and clearing the pointers empties the FIFO.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         tag_mem[wr_ptr_r] <= grant_id;
      end
   end

   // Simulation-only protocol checks.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(accept && !resp_deq && credit_cnt_r == max_credits_lp))
            else $error("io_cmd_arbiter: credit counter overflow");
         assert (!(resp_deq && !accept && credit_cnt_r == '0))
            else $error("io_cmd_arbiter: credit counter underflow");
         assert (!(io_resp_v_i && fifo_empty))
            else $warning("io_cmd_arbiter: io_resp_v_i with no command in flight; response not consumed");
      end
   end

endmodule

// File: tb/tb_bp_nonsynth_io_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bp_nonsynth_io_cmd_arbiter
//
// Directed scenarios plus a randomized run. Expected values come from a
// transaction-level model: a queue of outstanding requester ids, a
// round-robin priority index and a "locked requester" id.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_bp_nonsynth_io_cmd_arbiter;

   localparam int N    = 2;
   localparam int MAXC = 2;
   localparam int W    = 16;

   logic           clk_i = 1'b0;
   logic           reset_i;
   logic [N*W-1:0] req_cmd_i;
   logic [N-1:0]   req_cmd_v_i;
   logic [N-1:0]   req_cmd_yumi_o;
   logic [W-1:0]   req_resp_o;
   logic [N-1:0]   req_resp_v_o;
   logic [N-1:0]   req_resp_ready_i;
   logic [W-1:0]   io_cmd_o;
   logic           io_cmd_v_o;
   logic           io_cmd_yumi_i;
   logic [W-1:0]   io_resp_i;
   logic           io_resp_v_i;
   logic           io_resp_ready_o;
   logic           idle_o;

   logic [W-1:0]   msg_m [N];

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int tagq[$];
   int rr_m     = 0;
   int lock_m   = -1;
   int last_acc = -1;

   always #5 clk_i = ~clk_i;

   for (genvar gi = 0; gi < N; gi++) begin : g_cmd
      assign req_cmd_i[gi*W +: W] = msg_m[gi];
   end

   bp_nonsynth_io_cmd_arbiter #(
      .num_req_p     (N),
      .max_credits_p (MAXC),
      .msg_width_p   (W)
   ) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .req_cmd_i        (req_cmd_i),
      .req_cmd_v_i      (req_cmd_v_i),
      .req_cmd_yumi_o   (req_cmd_yumi_o),
      .req_resp_o       (req_resp_o),
      .req_resp_v_o     (req_resp_v_o),
      .req_resp_ready_i (req_resp_ready_i),
      .io_cmd_o         (io_cmd_o),
      .io_cmd_v_o       (io_cmd_v_o),
      .io_cmd_yumi_i    (io_cmd_yumi_i),
      .io_resp_i        (io_resp_i),
      .io_resp_v_i      (io_resp_v_i),
      .io_resp_ready_o  (io_resp_ready_o),
      .idle_o           (idle_o)
   );

   // ---------------- reference model ----------------
   function automatic int m_pick();
      if (lock_m >= 0) return lock_m;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (i == (rr_m + k) % N && req_cmd_v_i[i]) return i;
         end
      end
      return -1;
   endfunction

   function automatic bit m_cmd_v();
      return (m_pick() >= 0) && (tagq.size() < MAXC);
   endfunction

   function automatic logic [W-1:0] m_cmd();
      logic [W-1:0] m;
      int g;
      m = '0;
      g = m_pick();
      for (int i = 0; i < N; i++) if (i == g) m = msg_m[i];
      return m;
   endfunction

   function automatic logic [N-1:0] m_yumi();
      logic [N-1:0] y;
      int g;
      y = '0;
      g = m_pick();
      if (m_cmd_v() && io_cmd_yumi_i) begin
         for (int i = 0; i < N; i++) if (i == g) y[i] = 1'b1;
      end
      return y;
   endfunction

   function automatic logic m_resp_ready();
      logic r;
      r = 1'b0;
      if (tagq.size() > 0) begin
         for (int i = 0; i < N; i++) if (i == tagq[0]) r = req_resp_ready_i[i];
      end
      return r;
   endfunction

   function automatic logic [N-1:0] m_resp_v();
      logic [N-1:0] r;
      r = '0;
      if (io_resp_v_i && tagq.size() > 0) begin
         for (int i = 0; i < N; i++) if (i == tagq[0]) r[i] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic m_idle();
      return (lock_m < 0) && (tagq.size() == 0);
   endfunction

   // Advance the model with the inputs present before the edge, then clock.
   task automatic tick();
      int  g;
      bit  cv;
      bit  acc;
      bit  deq;
      int  dummy;
      if (reset_i) begin
         tagq.delete();
         rr_m     = 0;
         lock_m   = -1;
         last_acc = -1;
      end else begin
         g   = m_pick();
         cv  = m_cmd_v();
         acc = cv && io_cmd_yumi_i;
         deq = io_resp_v_i && m_resp_ready();
         last_acc = acc ? g : -1;
         if (deq) dummy = tagq.pop_front();
         if (acc) begin
            tagq.push_back(g);
            rr_m   = (g + 1) % N;
            lock_m = -1;
         end else if (cv && lock_m < 0) begin
            lock_m = g;
         end
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle_inputs();
      req_cmd_v_i      = '0;
      io_cmd_yumi_i    = 1'b0;
      io_resp_v_i      = 1'b0;
      io_resp_i        = '0;
      req_resp_ready_i = '1;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset_i = 1'b1;
      tick();
      tick();
      reset_i = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      #1;
      checks++;
      if ({io_cmd_v_o, req_cmd_yumi_o, req_resp_v_o, io_resp_ready_o, idle_o} !== {1'b0, 2'b00, 2'b00, 1'b0, 1'b1})
         begin errors++; $display("FAIL reset_outputs got v=%0b yumi=%b rv=%b rr=%0b idle=%0b want v=0 yumi=00 rv=00 rr=0 idle=1",
            io_cmd_v_o, req_cmd_yumi_o, req_resp_v_o, io_resp_ready_o, idle_o); end
   endtask

   task automatic test_single();
      logic [W-1:0] data;
      apply_reset();
      msg_m[0] = W'($urandom);
      req_cmd_v_i = 2'b01; io_cmd_yumi_i = 1'b1;
      #1;
      checks++;
      if ({io_cmd_v_o, req_cmd_yumi_o} !== 3'b1_01 || io_cmd_o !== msg_m[0])
         begin errors++; $display("FAIL single_issue got v=%0b yumi=%b cmd=%h want v=1 yumi=01 cmd=%h",
            io_cmd_v_o, req_cmd_yumi_o, io_cmd_o, msg_m[0]); end
      tick();
      req_cmd_v_i = '0; io_cmd_yumi_i = 1'b0;
      #1;
      checks++;
      if (idle_o !== 1'b0) begin errors++; $display("FAIL single_busy got idle=%0b want 0", idle_o); end
      data = W'($urandom);
      io_resp_v_i = 1'b1; io_resp_i = data;
      #1;
      checks++;
      if ({req_resp_v_o, io_resp_ready_o} !== 3'b01_1 || req_resp_o !== data)
         begin errors++; $display("FAIL single_resp got rv=%b rr=%0b data=%h want rv=01 rr=1 data=%h",
            req_resp_v_o, io_resp_ready_o, req_resp_o, data); end
      tick();
      io_resp_v_i = 1'b0;
      #1;
      checks++;
      if (idle_o !== 1'b1) begin errors++; $display("FAIL single_idle got idle=%0b want 1", idle_o); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] want;
      apply_reset();
      for (int i = 0; i < N; i++) msg_m[i] = W'($urandom);
      req_cmd_v_i = 2'b11; io_cmd_yumi_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
         io_resp_v_i = (tagq.size() > 0);
         io_resp_i   = W'($urandom);
         #1;
         want = (c % 2 == 0) ? 2'b01 : 2'b10;
         checks++;
         if (req_cmd_yumi_o !== want || io_cmd_o !== msg_m[c % 2])
            begin errors++; $display("FAIL rr_grant_%0d got yumi=%b cmd=%h want yumi=%b cmd=%h",
               c, req_cmd_yumi_o, io_cmd_o, want, msg_m[c % 2]); end
         checks++;
         if (req_resp_v_o !== m_resp_v())
            begin errors++; $display("FAIL rr_resp_%0d got rv=%b want %b", c, req_resp_v_o, m_resp_v()); end
         tick();
         if (last_acc >= 0) msg_m[last_acc] = W'($urandom);
      end
      idle_inputs();
   endtask

   task automatic test_lock();
      apply_reset();
      msg_m[0] = W'($urandom);
      msg_m[1] = W'($urandom);
      req_cmd_v_i = 2'b10; io_cmd_yumi_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) req_cmd_v_i = 2'b11;
         #1;
         checks++;
         if ({io_cmd_v_o, req_cmd_yumi_o} !== 3'b1_00 || io_cmd_o !== msg_m[1])
            begin errors++; $display("FAIL lock_hold_%0d got v=%0b yumi=%b cmd=%h want v=1 yumi=00 cmd=%h",
               c, io_cmd_v_o, req_cmd_yumi_o, io_cmd_o, msg_m[1]); end
         tick();
      end
      io_cmd_yumi_i = 1'b1;
      #1;
      checks++;
      if (req_cmd_yumi_o !== 2'b10 || io_cmd_o !== msg_m[1])
         begin errors++; $display("FAIL lock_accept got yumi=%b cmd=%h want yumi=10 cmd=%h",
            req_cmd_yumi_o, io_cmd_o, msg_m[1]); end
      tick();
      req_cmd_v_i = 2'b01;
      #1;
      checks++;
      if (req_cmd_yumi_o !== 2'b01 || io_cmd_o !== msg_m[0])
         begin errors++; $display("FAIL lock_next got yumi=%b cmd=%h want yumi=01 cmd=%h",
            req_cmd_yumi_o, io_cmd_o, msg_m[0]); end
      tick();
      idle_inputs();
   endtask

   task automatic test_credits();
      apply_reset();
      msg_m[0] = W'($urandom);
      req_cmd_v_i = 2'b01; io_cmd_yumi_i = 1'b1;
      for (int c = 0; c < MAXC; c++) begin
         #1;
         checks++;
         if (req_cmd_yumi_o !== 2'b01)
            begin errors++; $display("FAIL credit_issue_%0d got yumi=%b want 01", c, req_cmd_yumi_o); end
         tick();
         msg_m[0] = W'($urandom);
      end
      #1;
      checks++;
      if ({io_cmd_v_o, req_cmd_yumi_o, idle_o} !== 4'b0_00_0)
         begin errors++; $display("FAIL credit_full got v=%0b yumi=%b idle=%0b want v=0 yumi=00 idle=0",
            io_cmd_v_o, req_cmd_yumi_o, idle_o); end
      tick();
      io_resp_v_i = 1'b1; io_resp_i = W'($urandom);
      #1;
      checks++;
      if ({io_resp_ready_o, io_cmd_v_o} !== 2'b10)
         begin errors++; $display("FAIL credit_resp got rr=%0b v=%0b want rr=1 v=0", io_resp_ready_o, io_cmd_v_o); end
      tick();
      io_resp_v_i = 1'b0;
      #1;
      checks++;
      if ({io_cmd_v_o, req_cmd_yumi_o} !== 3'b1_01 || io_cmd_o !== msg_m[0])
         begin errors++; $display("FAIL credit_resume got v=%0b yumi=%b cmd=%h want v=1 yumi=01 cmd=%h",
            io_cmd_v_o, req_cmd_yumi_o, io_cmd_o, msg_m[0]); end
      tick();
      idle_inputs();
   endtask

   task automatic test_resp_order();
      apply_reset();
      req_cmd_v_i = 2'b01; io_cmd_yumi_i = 1'b1;
      tick();
      req_cmd_v_i = 2'b10;
      tick();
      req_cmd_v_i = '0; io_cmd_yumi_i = 1'b0;
      io_resp_v_i = 1'b1; io_resp_i = W'($urandom); req_resp_ready_i = 2'b10;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if ({req_resp_v_o, io_resp_ready_o} !== 3'b01_0)
            begin errors++; $display("FAIL order_stall_%0d got rv=%b rr=%0b want rv=01 rr=0", c, req_resp_v_o, io_resp_ready_o); end
         tick();
      end
      req_resp_ready_i = 2'b11;
      #1;
      checks++;
      if ({req_resp_v_o, io_resp_ready_o} !== 3'b01_1)
         begin errors++; $display("FAIL order_first got rv=%b rr=%0b want rv=01 rr=1", req_resp_v_o, io_resp_ready_o); end
      tick();
      io_resp_i = W'($urandom);
      #1;
      checks++;
      if ({req_resp_v_o, io_resp_ready_o} !== 3'b10_1 || req_resp_o !== io_resp_i)
         begin errors++; $display("FAIL order_second got rv=%b rr=%0b want rv=10 rr=1", req_resp_v_o, io_resp_ready_o); end
      tick();
      io_resp_v_i = 1'b0;
      #1;
      checks++;
      if (idle_o !== 1'b1) begin errors++; $display("FAIL order_idle got idle=%0b want 1", idle_o); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req_cmd_v_i = 2'b11; io_cmd_yumi_i = 1'b1;
      tick();
      tick();
      req_cmd_v_i = '0; io_cmd_yumi_i = 1'b0;
      #1;
      checks++;
      if (idle_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got idle=%0b want 0", idle_o); end
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      #1;
      checks++;
      if ({idle_o, io_cmd_v_o} !== 2'b10)
         begin errors++; $display("FAIL midrst_clear got idle=%0b v=%0b want idle=1 v=0", idle_o, io_cmd_v_o); end
      io_resp_v_i = 1'b1; io_resp_i = W'($urandom);
      #1;
      checks++;
      if ({io_resp_ready_o, req_resp_v_o} !== 3'b0_00)
         begin errors++; $display("FAIL midrst_stray got rr=%0b rv=%b want rr=0 rv=00", io_resp_ready_o, req_resp_v_o); end
      tick();
      io_resp_v_i = 1'b0;
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_cmd_v_i[i] && $urandom_range(0, 2) == 0) begin
               req_cmd_v_i[i] = 1'b1;
               msg_m[i]       = W'($urandom);
            end
         end
         io_cmd_yumi_i    = 1'($urandom_range(0, 1));
         req_resp_ready_i = N'($urandom);
         io_resp_v_i      = (tagq.size() > 0) && ($urandom_range(0, 1) == 1);
         io_resp_i        = W'($urandom);
         #1;
         checks++;
         if (io_cmd_v_o !== m_cmd_v() || req_cmd_yumi_o !== m_yumi())
            begin errors++; $display("FAIL rand_cmd_%0d got v=%0b yumi=%b want v=%0b yumi=%b",
               c, io_cmd_v_o, req_cmd_yumi_o, m_cmd_v(), m_yumi()); end
         if (m_cmd_v()) begin
            checks++;
            if (io_cmd_o !== m_cmd())
               begin errors++; $display("FAIL rand_msg_%0d got %h want %h", c, io_cmd_o, m_cmd()); end
         end
         checks++;
         if (req_resp_v_o !== m_resp_v() || io_resp_ready_o !== m_resp_ready())
            begin errors++; $display("FAIL rand_resp_%0d got rv=%b rr=%0b want rv=%b rr=%0b",
               c, req_resp_v_o, io_resp_ready_o, m_resp_v(), m_resp_ready()); end
         checks++;
         if (idle_o !== m_idle())
            begin errors++; $display("FAIL rand_idle_%0d got %0b want %0b", c, idle_o, m_idle()); end
         tick();
         for (int i = 0; i < N; i++) if (i == last_acc) req_cmd_v_i[i] = 1'b0;
      end
      idle_inputs();
   endtask

   initial begin
      reset_i = 1'b1;
      for (int i = 0; i < N; i++) msg_m[i] = '0;
      idle_inputs();
      @(negedge clk_i);
      test_reset();
      test_single();
      test_round_robin();
      test_lock();
      test_credits();
      test_resp_order();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
